// File: rtl/fpu_pkg.sv
// Shared definitions for the FP32 adder feeder: widths, the adder's NaN
// encoding, the sequencer state type and the debug bundle.
package fpu_pkg;

    localparam int FP32_W = 32;
    localparam int PAIR_W = 2 * FP32_W;

    // Canonical NaN produced by the downstream adder (e.g. +inf + -inf).
    localparam logic [FP32_W-1:0] QNAN_NEG = 32'hFFC0_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT_Z = 2'd2,
        WAIT_V = 2'd3
    } feeder_state_e;

    // Observability bundle: current sequencer state plus operand-ack monitors
    // for the transaction in flight (cleared at each dispatch).
    typedef struct packed {
        feeder_state_e state;
        logic          a_ack_seen;
        logic          b_ack_seen;
    } feeder_dbg_t;

    // Operand pairs are stored as {a, b}, with a in the upper half.
    function automatic logic [PAIR_W-1:0] pack_pair(input logic [FP32_W-1:0] a,
                                                    input logic [FP32_W-1:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of W bits, registered count, asynchronous
// active-low clear. Pushes while full and pops while empty are ignored.
module fpu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state for storage, pointers (power-of-2 wrap) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpu_add_feeder.sv
// Operand sequencer in front of the FP32 adder. Queues operand pairs, runs
// the adder start/ack/strobe/valid handshake one transaction at a time, and
// returns sums in order through a one-entry result register.
//
// Handshakes: an operand pair transfers on a clock edge where op_valid and
// op_ready are both high; a result transfers on an edge where res_valid and
// res_ready are both high. Neither valid depends on its ready.
module fpu_add_feeder
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FP32_W-1:0]       op_a,
    input  logic [FP32_W-1:0]       op_b,
    input  logic                    op_valid,
    output logic                    op_ready,
    output logic [FP32_W-1:0]       res_z,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    timeout_err,
    output logic                    add_start,
    output logic [FP32_W-1:0]       add_input_a,
    output logic [FP32_W-1:0]       add_input_b,
    input  logic                    add_input_a_ack,
    input  logic                    add_input_b_ack,
    input  logic [FP32_W-1:0]       add_output_z,
    input  logic                    add_output_z_stb,
    input  logic                    add_output_valid,
    input  logic                    add_idle_status,
    output logic                    add_ack_output,
    output feeder_dbg_t             dbg
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    feeder_state_e     state_q, state_d;
    logic [FP32_W-1:0] add_a_q, add_a_d;
    logic [FP32_W-1:0] add_b_q, add_b_d;
    logic [FP32_W-1:0] res_z_q, res_z_d;
    logic              res_valid_q, res_valid_d;
    logic              add_start_q, add_start_d;
    logic              add_ack_q, add_ack_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic              terr_q, terr_d;
    logic              a_seen_q, a_seen_d;
    logic              b_seen_q, b_seen_d;
    logic              wd_inc;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PAIR_W-1:0] fifo_rd;

    assign op_ready = !fifo_full;
    assign push     = op_valid && op_ready;
    // Dispatch only when the adder reports idle; this also holds off any
    // start after reset until the adder has come out of its own reset.
    assign pop      = (state_q == IDLE) && !fifo_empty && add_idle_status;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .W     (PAIR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (push),
        .wr_data (pack_pair(op_a, op_b)),
        .pop     (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sequencer next state, result capture/drain and watchdog accounting.
    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_z_d     = res_z_q;
        res_valid_d = res_valid_q;
        wd_d        = wd_q;
        wd_inc      = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    add_a_d = fifo_rd[PAIR_W-1:FP32_W];
                    add_b_d = fifo_rd[FP32_W-1:0];
                    wd_d    = '0;
                    state_d = START;
                end
            end
            START: begin
                wd_inc  = 1'b1;
                state_d = WAIT_Z;
            end
            WAIT_Z: begin
                // A held result stalls the adder; that time is not charged.
                wd_inc = !res_valid_q;
                // add_ack_q is high here only while the result slot is empty,
                // so a capture never coincides with a drain.
                if (add_output_z_stb && add_ack_q) begin
                    res_z_d     = add_output_z;
                    res_valid_d = 1'b1;
                    state_d     = WAIT_V;
                end
            end
            WAIT_V: begin
                wd_inc = 1'b1;
                if (add_output_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wd_inc && (wd_q != WD_MAX)) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    // Registered adder controls and monitors, derived from the next state.
    always_comb begin
        add_start_d = (state_d == START);
        add_ack_d   = ((state_d == WAIT_Z) && !res_valid_d) || (state_d == WAIT_V);
        terr_d      = terr_q || (wd_d == WD_MAX);
        a_seen_d    = pop ? 1'b0 : (a_seen_q || add_input_a_ack);
        b_seen_d    = pop ? 1'b0 : (b_seen_q || add_input_b_ack);
    end

    // Sequencer state and all registered outputs; reset applies immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_z_q     <= '0;
            res_valid_q <= 1'b0;
            add_start_q <= 1'b0;
            add_ack_q   <= 1'b0;
            wd_q        <= '0;
            terr_q      <= 1'b0;
            a_seen_q    <= 1'b0;
            b_seen_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_z_q     <= res_z_d;
            res_valid_q <= res_valid_d;
            add_start_q <= add_start_d;
            add_ack_q   <= add_ack_d;
            wd_q        <= wd_d;
            terr_q      <= terr_d;
            a_seen_q    <= a_seen_d;
            b_seen_q    <= b_seen_d;
        end
    end

    assign res_z          = res_z_q;
    assign res_valid      = res_valid_q;
    assign add_start      = add_start_q;
    assign add_input_a    = add_a_q;
    assign add_input_b    = add_b_q;
    assign add_ack_output = add_ack_q;
    assign timeout_err    = terr_q;

    assign dbg.state      = state_q;
    assign dbg.a_ack_seen = a_seen_q;
    assign dbg.b_ack_seen = b_seen_q;

endmodule

// File: tb/tb_fpu_add_feeder.sv
// Directed bench for fpu_add_feeder with a small behavioural adder that
// follows the start / ack / strobe / valid / idle handshake.
module tb_fpu_add_feeder;
    import fpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] op_a, op_b;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] res_z;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  fifo_count;
    logic        timeout_err;
    logic        add_start;
    logic [31:0] add_input_a, add_input_b;
    logic        add_input_a_ack, add_input_b_ack;
    logic [31:0] add_output_z;
    logic        add_output_z_stb;
    logic        add_output_valid;
    logic        add_idle_status;
    logic        add_ack_output;
    feeder_dbg_t dbg;

    fpu_add_feeder #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .op_a             (op_a),
        .op_b             (op_b),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .res_z            (res_z),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .fifo_count       (fifo_count),
        .timeout_err      (timeout_err),
        .add_start        (add_start),
        .add_input_a      (add_input_a),
        .add_input_b      (add_input_b),
        .add_input_a_ack  (add_input_a_ack),
        .add_input_b_ack  (add_input_b_ack),
        .add_output_z     (add_output_z),
        .add_output_z_stb (add_output_z_stb),
        .add_output_valid (add_output_valid),
        .add_idle_status  (add_idle_status),
        .add_ack_output   (add_ack_output),
        .dbg              (dbg)
    );

    // ---------------- adder model ----------------
    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_GET  = 3'd1;
    localparam logic [2:0] M_PUT  = 3'd2;
    localparam logic [2:0] M_DONE = 3'd3;
    localparam logic [2:0] M_REC  = 3'd4;

    logic [2:0]  m_st;
    logic [7:0]  m_cnt;
    logic [31:0] m_a, m_b, m_z;
    logic        idle_en;
    logic        adder_hang;
    logic [7:0]  lat;

    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h3F80_0000, 32'h4040_0000}: return 32'h4080_0000;
            {32'h3F80_0000, 32'h4080_0000}: return 32'h40A0_0000;
            {32'h3F80_0000, 32'h40A0_0000}: return 32'h40C0_0000;
            {32'h7F80_0000, 32'hFF80_0000}: return QNAN_NEG;
            {32'h3F80_0000, 32'hBF80_0000}: return 32'h0000_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st  <= M_IDLE;
            m_cnt <= '0;
            m_a   <= '0;
            m_b   <= '0;
            m_z   <= '0;
        end else begin
            case (m_st)
                M_IDLE: if (add_start) begin
                    m_a   <= add_input_a;
                    m_b   <= add_input_b;
                    m_cnt <= lat;
                    m_st  <= M_GET;
                end
                M_GET: if (!adder_hang) begin
                    if (m_cnt == 0) begin
                        m_z  <= fake_add(m_a, m_b);
                        m_st <= M_PUT;
                    end else begin
                        m_cnt <= m_cnt - 8'd1;
                    end
                end
                M_PUT:  if (add_ack_output) m_st <= M_DONE;
                M_DONE: if (add_ack_output) m_st <= M_REC;
                default: m_st <= M_IDLE;
            endcase
        end
    end

    assign add_output_z     = m_z;
    assign add_output_z_stb = (m_st == M_PUT);
    assign add_output_valid = (m_st == M_DONE);
    assign add_idle_status  = (m_st == M_IDLE) && idle_en;
    assign add_input_a_ack  = (m_st == M_GET);
    assign add_input_b_ack  = (m_st == M_GET);

    // ---------------- scoreboard / monitor ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          start_cnt = 0;
    int          rv_cycles = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (res_valid && res_ready) got_q.push_back(res_z);
            if (add_start) start_cnt++;
            if (res_valid) rv_cycles++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        logic acc;
        acc      = 1'b0;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (op_ready) acc = 1'b1;
            tick();
        end
        op_valid = 1'b0;
        chk("push_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (got_q.size() >= n && dbg.state == IDLE && m_st == M_IDLE) done = 1'b1;
            else tick();
        end
        chk("done_in_budget", {31'b0, done}, 32'd1);
    endtask

    task automatic check_sb(input string tag);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
            chk(tag, g, e);
        end
        chk({tag, "_extra"}, got_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_op_ready"},   {31'b0, op_ready},       32'd1);
        chk({tag, "_fifo_count"}, {29'b0, fifo_count},     32'd0);
        chk({tag, "_res_valid"},  {31'b0, res_valid},      32'd0);
        chk({tag, "_res_z"},      res_z,                   32'd0);
        chk({tag, "_add_start"},  {31'b0, add_start},      32'd0);
        chk({tag, "_add_in_a"},   add_input_a,             32'd0);
        chk({tag, "_add_in_b"},   add_input_b,             32'd0);
        chk({tag, "_add_ack"},    {31'b0, add_ack_output}, 32'd0);
        chk({tag, "_state"},      32'(dbg.state),          32'(IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic seen;
        op_a = '0; op_b = '0; op_valid = 1'b0; res_ready = 1'b1;
        idle_en = 1'b1; adder_hang = 1'b0; lat = 8'd3;

        // Reset values
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("rst");
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        ticks(2);
        rst = 1'b1;
        tick();

        // Single pair 1.0 + 2.0 with exact start timing
        rv_cycles = 0; start_cnt = 0;
        push(32'h3F80_0000, 32'h4000_0000);
        chk("t1_count_after_push", {29'b0, fifo_count}, 32'd1);
        chk("t1_no_start_yet", {31'b0, add_start}, 32'd0);
        tick();
        chk("t1_start", {31'b0, add_start}, 32'd1);
        chk("t1_add_a", add_input_a, 32'h3F80_0000);
        chk("t1_add_b", add_input_b, 32'h4000_0000);
        chk("t1_count_after_pop", {29'b0, fifo_count}, 32'd0);
        tick();
        chk("t1_start_one_cycle", {31'b0, add_start}, 32'd0);
        exp_q.push_back(32'h4040_0000);
        wait_done(1, 100);
        check_sb("t1_res");
        chk("t1_start_count", start_cnt, 32'd1);
        chk("t1_res_valid_cycles", rv_cycles, 32'd1);
        chk("t1_a_ack_seen", {31'b0, dbg.a_ack_seen}, 32'd1);
        chk("t1_b_ack_seen", {31'b0, dbg.b_ack_seen}, 32'd1);

        // Five pairs; fill the FIFO while the adder is held busy
        start_cnt = 0;
        idle_en = 1'b0;
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h3F80_0000, 32'h4000_0000);
        push(32'h3F80_0000, 32'h4040_0000);
        push(32'h3F80_0000, 32'h4080_0000);
        chk("t2_full_count", {29'b0, fifo_count}, 32'd4);
        chk("t2_op_ready_low", {31'b0, op_ready}, 32'd0);
        op_a = 32'h3F80_0000; op_b = 32'h40A0_0000; op_valid = 1'b1;
        tick();
        chk("t2_push_ignored", {29'b0, fifo_count}, 32'd4);
        idle_en = 1'b1;
        push(32'h3F80_0000, 32'h40A0_0000);
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4040_0000);
        exp_q.push_back(32'h4080_0000);
        exp_q.push_back(32'h40A0_0000);
        exp_q.push_back(32'h40C0_0000);
        wait_done(5, 300);
        check_sb("t2_res");
        chk("t2_start_count", start_cnt, 32'd5);

        // Consumer stall across two transactions
        res_ready = 1'b0;
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h3F80_0000, 32'h4000_0000);
        ticks(30);
        chk("t3_held_valid", {31'b0, res_valid}, 32'd1);
        chk("t3_held_z", res_z, 32'h4000_0000);
        chk("t3_stb_pending", {31'b0, add_output_z_stb}, 32'd1);
        chk("t3_ack_low", {31'b0, add_ack_output}, 32'd0);
        chk("t3_state", 32'(dbg.state), 32'(WAIT_Z));
        chk("t3_nothing_out", got_q.size(), 32'd0);
        res_ready = 1'b1;
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4040_0000);
        wait_done(2, 100);
        check_sb("t3_res");

        // Special values: exact zero, then inf + -inf
        push(32'h3F80_0000, 32'hBF80_0000);
        push(32'h7F80_0000, 32'hFF80_0000);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'hFFC0_0000);
        wait_done(2, 100);
        check_sb("t4_res");
        chk("t4_no_timeout", {31'b0, timeout_err}, 32'd0);

        // Reset mid-transaction with three pairs queued
        idle_en = 1'b0;
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h3F80_0000, 32'h4000_0000);
        push(32'h3F80_0000, 32'h4040_0000);
        push(32'h3F80_0000, 32'h4080_0000);
        chk("t5_count4", {29'b0, fifo_count}, 32'd4);
        idle_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (dbg.state == WAIT_Z) seen = 1'b1;
            else tick();
        end
        chk("t5_reached_wait_z", {31'b0, seen}, 32'd1);
        chk("t5_count3", {29'b0, fifo_count}, 32'd3);
        chk("t5_held_res_z", res_z, 32'hFFC0_0000);
        rst = 1'b0;
        idle_en = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick();
        rst = 1'b1;
        start_cnt = 0;
        ticks(10);
        push(32'h3F80_0000, 32'h4000_0000);
        ticks(5);
        chk("t5_no_start_while_busy", start_cnt, 32'd0);
        chk("t5_count1", {29'b0, fifo_count}, 32'd1);
        idle_en = 1'b1;
        exp_q.push_back(32'h4040_0000);
        wait_done(1, 100);
        check_sb("t5_res");
        chk("t5_start_count", start_cnt, 32'd1);

        // Hung adder: watchdog fires TIMEOUT cycles after the start pulse
        adder_hang = 1'b1;
        push(32'h3F80_0000, 32'h3F80_0000);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (add_start) seen = 1'b1;
            else tick();
        end
        chk("t6_start_seen", {31'b0, seen}, 32'd1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (timeout_err) break;
        end
        chk("t6_timeout_latency", n, 32'd16);
        ticks(20);
        chk("t6_timeout_sticky", {31'b0, timeout_err}, 32'd1);
        chk("t6_no_abort", 32'(dbg.state), 32'(WAIT_Z));
        rst = 1'b0;
        #1;
        chk("t6_timeout_cleared", {31'b0, timeout_err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_add_feeder.md
# fpu_add_feeder

Operand sequencer placed directly upstream of the FP32 adder. It buffers operand pairs from a valid/ready source in a small FIFO and runs the adder's start / a-ack / b-ack / z-strobe / output-valid handshake. It returns each sum through a one-entry valid/ready result register, in order, one transaction at a time. It also detects a hung adder with a watchdog.

## Interface
- DEPTH, 4: operand FIFO depth in pairs; must be a power of 2 and at least 2.
- TIMEOUT, 1024: cycles allowed per adder transaction before the watchdog fires.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- op_a, op_b  in  32  FP32 operands
- op_valid  in  1  operand pair offered
- op_ready  out  1  FIFO not full (count < DEPTH)
- res_z  out  32  FP32 sum
- res_valid  out  1  res_z holds an unconsumed result
- res_ready  in  1  consumer accepts res_z
- fifo_count  out  $clog2(DEPTH)+1  operand pairs currently queued
- timeout_err  out  1  sticky watchdog flag
- add_start  out  1  one-cycle start pulse to the adder
- add_input_a, add_input_b  out  32  operands presented to the adder
- add_input_a_ack, add_input_b_ack  in  1  adder operand acks (monitor only)
- add_output_z  in  32  adder result
- add_output_z_stb  in  1  adder result strobe
- add_output_valid  in  1  adder completion flag
- add_idle_status  in  1  adder idle
- add_ack_output  out  1  result/completion acknowledge to the adder

## Operation

**Reset values** (while rst=0, applied immediately):
- state IDLE, FIFO emptied, fifo_count=0, so op_ready=1.
- res_valid=0, res_z=0.
- add_start=0, add_input_a=0, add_input_b=0, add_ack_output=0.
- timeout_err=0, watchdog=0.

**FIFO**
- Push on op_valid && op_ready.
- Pop only on dispatch; there is no bypass.
- A push and a pop in the same cycle leave the count unchanged.
- When full, op_ready=0 and op_valid is ignored.

**FSM**
- IDLE: if fifo_count≠0 and add_idle_status=1, pop the head into the add_input_a/add_input_b hold registers and go to START.
- START: add_start=1 for exactly this cycle, then go to WAIT_Z.
- WAIT_Z: add_ack_output = !res_valid. On add_output_z_stb && add_ack_output, load res_z ← add_output_z, set res_valid, and go to WAIT_V.
- WAIT_V: add_ack_output=1. On add_output_valid=1, go to IDLE.
- add_input_a and add_input_b hold their values from dispatch until the next dispatch. The adder samples them at any point during its get_a/get_b states.

**Result register**
- Clears on res_valid && res_ready.
- A capture and a drain can never occur in the same cycle, because a capture requires res_valid=0.

**Watchdog**
- Cleared on entry to START.
- Increments each cycle in START, WAIT_Z and WAIT_V, except WAIT_Z cycles where res_valid=1 (consumer stall).
- When it reaches TIMEOUT, timeout_err is set and stays set until reset. The FSM does not abort.

**Adder reset relation**
- The adder's active-high reset is driven from the same system reset.
- After any reset, no add_start is issued until add_idle_status=1 is observed.

## Timing
- A pair accepted at edge E0 reaches the head of an empty FIFO. add_start is high in the cycle after edge E0+1, provided add_idle_status=1.
- res_valid rises on the same edge at which the adder leaves its strobe state.
- After WAIT_V, the next dispatch comes no earlier than 2 cycles later, because add_idle_status re-asserts one cycle after the adder returns to idle.
- Sustained throughput is one pair per (adder latency + 4) cycles.
- Results leave in acceptance order; none are dropped or duplicated.
- Asserting rst mid-transaction discards queued pairs and any held result.

## Structure
- Shared package fpu_pkg holds:
  - FP32_W=32
  - QNAN_NEG=32'hFFC0_0000 (the adder's NaN encoding)
  - the FSM state enum {IDLE, START, WAIT_Z, WAIT_V}
- One sub-module, fpu_op_fifo: a synchronous 64-bit-wide FIFO of DEPTH entries with count output and an asynchronous active-low clear.

## Test plan
- Single pair 3F800000 + 40000000, res_ready=1 → exactly one add_start pulse, res_z=40400000, res_valid high for 1 cycle.
- Five back-to-back pairs (1.0+1.0, 1.0+2.0, …) with DEPTH=4 → op_ready drops when fifo_count=4; results 40000000, 40400000, … arrive in order.
- res_ready=0 across two transactions → second add_output_z_stb held with add_ack_output=0, no loss. Raising res_ready delivers both results in order.
- 7F800000 + FF800000 → res_z=FFC00000. 3F800000 + BF800000 → res_z=00000000.
- rst low during WAIT_Z with 3 pairs queued → all outputs take reset values immediately, fifo_count=0. No add_start until add_idle_status=1.
- Adder model that never strobes, TIMEOUT=16 → timeout_err rises 16 cycles after add_start and stays high until reset.
